// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the multi-cycle CPU: opcodes, ALU function codes and
// the control-unit state encoding. The ALU imports the same func codes.
package cpu_defs_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_SHL  = 4'h6;
    localparam logic [3:0] OP_SHR  = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_JZ   = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_OR   = 3'b100;
    localparam logic [2:0] ALU_SHL  = 3'b101;
    localparam logic [2:0] ALU_SHR  = 3'b110;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WAIT   = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    function automatic logic [3:0] opcode_of(input logic [15:0] word);
        return word[15:12];
    endfunction

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Opcode decoder: maps a 4-bit opcode to ALU function, operand-B select and
// the instruction-class flags used by the control FSM.
module cpu_ctrl_decode
    import cpu_defs_pkg::*;
(
    input  logic [3:0] opcode,
    output logic [2:0] alu_func,
    output logic       sel_imm,
    output logic       is_alu,
    output logic       is_jmp,
    output logic       is_jz,
    output logic       is_halt
);

    always_comb begin
        alu_func = ALU_PASS;
        sel_imm  = 1'b0;
        is_alu   = 1'b0;
        is_jmp   = 1'b0;
        is_jz    = 1'b0;
        is_halt  = 1'b0;
        case (opcode)
            OP_NOP:  ;
            OP_LDI:  begin alu_func = ALU_PASS; sel_imm = 1'b1; is_alu = 1'b1; end
            OP_ADD:  begin alu_func = ALU_ADD; is_alu = 1'b1; end
            OP_SUB:  begin alu_func = ALU_SUB; is_alu = 1'b1; end
            OP_AND:  begin alu_func = ALU_AND; is_alu = 1'b1; end
            OP_OR:   begin alu_func = ALU_OR;  is_alu = 1'b1; end
            OP_SHL:  begin alu_func = ALU_SHL; is_alu = 1'b1; end
            OP_SHR:  begin alu_func = ALU_SHR; is_alu = 1'b1; end
            OP_JMP:  is_jmp  = 1'b1;
            OP_JZ:   is_jz   = 1'b1;
            OP_HALT: is_halt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl_unit.sv
// Multi-cycle control unit: fetch/decode/execute sequencing, PC, zero flag and
// halt state. All outputs are registered so they are glitch-free to the ALU.
module cpu_ctrl_unit
    import cpu_defs_pkg::*;
#(
    parameter int PC_W   = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [PC_W-1:0]   imem_addr,
    output logic              imem_req,
    input  logic [DATA_W-1:0] imem_data,
    input  logic              imem_valid,
    output logic [2:0]        alu_func,
    output logic              alu_en_in,
    input  logic              alu_en_out,
    input  logic [DATA_W-1:0] alu_out,
    output logic [1:0]        rf_ra,
    output logic [1:0]        rf_rb,
    output logic [1:0]        rf_wa,
    output logic              rf_we,
    output logic              sel_imm,
    output logic [DATA_W-1:0] imm_ext,
    output logic              busy,
    output logic              halted,
    output logic [2:0]        state_dbg
);

    // Handshakes: imem_data is taken on the rising edge where imem_req and
    // imem_valid are both high; alu_en_in is a one-cycle request and the
    // result is taken on the first edge in WAIT where alu_en_out is high.

    state_t            state;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] ir;
    logic              z_reg;

    logic [3:0] dec_op;
    logic [2:0] dec_func;
    logic       dec_sel_imm;
    logic       is_alu;
    logic       is_jmp;
    logic       is_jz;
    logic       is_halt;

    // In FETCH the decoder looks at the incoming word so the operand and
    // function registers are already valid during the DECODE cycle.
    assign dec_op = (state == S_FETCH) ? opcode_of(imem_data[15:0]) : opcode_of(ir[15:0]);

    cpu_ctrl_decode u_decode (
        .opcode   (dec_op),
        .alu_func (dec_func),
        .sel_imm  (dec_sel_imm),
        .is_alu   (is_alu),
        .is_jmp   (is_jmp),
        .is_jz    (is_jz),
        .is_halt  (is_halt)
    );

    assign imem_addr = pc;
    assign imm_ext   = DATA_W'(ir[7:0]);
    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            pc        <= '0;
            ir        <= '0;
            z_reg     <= 1'b0;
            imem_req  <= 1'b0;
            alu_func  <= '0;
            alu_en_in <= 1'b0;
            rf_ra     <= '0;
            rf_rb     <= '0;
            rf_wa     <= '0;
            rf_we     <= 1'b0;
            sel_imm   <= 1'b0;
            busy      <= 1'b0;
            halted    <= 1'b0;
        end else begin
            alu_en_in <= 1'b0;
            rf_we     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_FETCH;
                        imem_req <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (imem_valid) begin
                        ir       <= imem_data;
                        imem_req <= 1'b0;
                        state    <= S_DECODE;
                        if (is_alu) begin
                            alu_func <= dec_func;
                            sel_imm  <= dec_sel_imm;
                            rf_wa    <= imem_data[11:10];
                            rf_ra    <= imem_data[9:8];
                            rf_rb    <= imem_data[7:6];
                        end
                    end
                end
                S_DECODE: begin
                    if (is_alu) begin
                        state     <= S_EXEC;
                        alu_en_in <= 1'b1;
                    end else if (is_halt) begin
                        state  <= S_HALT;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                    end else begin
                        state    <= S_FETCH;
                        imem_req <= 1'b1;
                        if (is_jmp || (is_jz && z_reg)) begin
                            pc <= PC_W'(ir[7:0]);
                        end else begin
                            pc <= pc + PC_W'(1);
                        end
                    end
                end
                S_EXEC: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // Zero flag is captured with the result itself, so it is
                    // settled by the time WB hands control back to FETCH.
                    if (alu_en_out) begin
                        state <= S_WB;
                        rf_we <= 1'b1;
                        if (opcode_of(ir[15:0]) == OP_SUB) begin
                            z_reg <= (alu_out == '0);
                        end
                    end
                end
                S_WB: begin
                    state    <= S_FETCH;
                    imem_req <= 1'b1;
                    pc       <= pc + PC_W'(1);
                    alu_func <= '0;
                    sel_imm  <= 1'b0;
                    rf_ra    <= '0;
                    rf_rb    <= '0;
                    rf_wa    <= '0;
                end
                S_HALT: ;
                default: begin
                    state    <= S_IDLE;
                    imem_req <= 1'b0;
                    busy     <= 1'b0;
                    halted   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_ctrl_unit.sv
// Bench for cpu_ctrl_unit: an instruction-level model expands each directed
// instruction into a per-cycle schedule of inputs and expected outputs.
`timescale 1ns/1ps
module tb_cpu_ctrl_unit;
    import cpu_defs_pkg::*;

    localparam int PC_W   = 8;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [PC_W-1:0]   imem_addr;
    logic              imem_req;
    logic [DATA_W-1:0] imem_data;
    logic              imem_valid;
    logic [2:0]        alu_func;
    logic              alu_en_in;
    logic              alu_en_out;
    logic [DATA_W-1:0] alu_out;
    logic [1:0]        rf_ra;
    logic [1:0]        rf_rb;
    logic [1:0]        rf_wa;
    logic              rf_we;
    logic              sel_imm;
    logic [DATA_W-1:0] imm_ext;
    logic              busy;
    logic              halted;
    logic [2:0]        state_dbg;

    cpu_ctrl_unit #(.PC_W(PC_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .imem_addr  (imem_addr),
        .imem_req   (imem_req),
        .imem_data  (imem_data),
        .imem_valid (imem_valid),
        .alu_func   (alu_func),
        .alu_en_in  (alu_en_in),
        .alu_en_out (alu_en_out),
        .alu_out    (alu_out),
        .rf_ra      (rf_ra),
        .rf_rb      (rf_rb),
        .rf_wa      (rf_wa),
        .rf_we      (rf_we),
        .sel_imm    (sel_imm),
        .imm_ext    (imm_ext),
        .busy       (busy),
        .halted     (halted),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        i_start;
        logic        i_valid;
        logic [15:0] i_data;
        logic        i_aen;
        logic [15:0] i_aout;
        logic        x_req;
        logic [7:0]  x_addr;
        logic [2:0]  x_func;
        logic        x_en_in;
        logic [1:0]  x_ra;
        logic [1:0]  x_rb;
        logic [1:0]  x_wa;
        logic        x_we;
        logic        x_sel;
        logic [15:0] x_imm;
        logic        x_busy;
        logic        x_halted;
        string       tag;
    } cyc_t;

    cyc_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc_no = 0;
    int          we_cnt = 0;
    int          en_cnt = 0;
    logic [7:0]  m_pc;
    logic [15:0] m_ir;
    bit          m_z;
    logic [38:0] dut_vec;

    assign dut_vec = {imem_req, imem_addr, alu_func, alu_en_in, rf_ra, rf_rb, rf_wa,
                      rf_we, sel_imm, imm_ext, busy, halted};

    always @(negedge clk) begin
        if (rf_we) we_cnt++;
        if (alu_en_in) en_cnt++;
    end

    function automatic logic [38:0] pack_x(cyc_t e);
        return {e.x_req, e.x_addr, e.x_func, e.x_en_in, e.x_ra, e.x_rb, e.x_wa,
                e.x_we, e.x_sel, e.x_imm, e.x_busy, e.x_halted};
    endfunction

    task automatic check_vec(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    // ISA table: which opcodes use the ALU, and with which func / operand B.
    task automatic op_table(input logic [3:0] op, output bit alu, output bit sel, output logic [2:0] fn);
        alu = (op >= 4'h1 && op <= 4'h7);
        sel = (op == 4'h1);
        fn  = alu ? 3'(op - 4'h1) : 3'b000;
    endtask

    function automatic cyc_t base(bit busy_v);
        cyc_t e;
        e.i_start  = 1'b0;
        e.i_valid  = 1'($urandom_range(0, 1));
        e.i_data   = 16'($urandom);
        e.i_aen    = 1'b0;
        e.i_aout   = 16'($urandom);
        e.x_req    = 1'b0;
        e.x_addr   = m_pc;
        e.x_func   = 3'b000;
        e.x_en_in  = 1'b0;
        e.x_ra     = 2'b00;
        e.x_rb     = 2'b00;
        e.x_wa     = 2'b00;
        e.x_we     = 1'b0;
        e.x_sel    = 1'b0;
        e.x_imm    = {8'h00, m_ir[7:0]};
        e.x_busy   = busy_v;
        e.x_halted = 1'b0;
        e.tag      = "";
        return e;
    endfunction

    function automatic cyc_t with_fields(cyc_t e, logic [2:0] fn, bit sel);
        e.x_func = fn;
        e.x_sel  = sel;
        e.x_wa   = m_ir[11:10];
        e.x_ra   = m_ir[9:8];
        e.x_rb   = m_ir[7:6];
        return e;
    endfunction

    task automatic t_idle(input bit st);
        cyc_t e;
        e = base(1'b0);
        e.tag = "idle";
        e.i_start = st;
        q.push_back(e);
    endtask

    // Memory answers after d wait cycles; ALU answers lat cycles into WAIT.
    task automatic t_instr(input logic [15:0] w, input int d, input int lat,
                           input logic [15:0] res, input bit noise, input bit finish);
        cyc_t e;
        bit alu, sel;
        logic [2:0] fn;
        logic [3:0] op;
        op = w[15:12];
        for (int i = 0; i <= d; i++) begin
            e = base(1'b1);
            e.tag = "fetch";
            e.x_req = 1'b1;
            e.i_valid = (i == d);
            if (i == d) e.i_data = w;
            if (noise) e.i_aen = 1'($urandom_range(0, 1));
            q.push_back(e);
        end
        m_ir = w;
        op_table(op, alu, sel, fn);
        e = base(1'b1);
        e.tag = "decode";
        if (alu) e = with_fields(e, fn, sel);
        if (noise) e.i_aen = 1'($urandom_range(0, 1));
        q.push_back(e);
        if (alu) begin
            e = with_fields(base(1'b1), fn, sel);
            e.tag = "exec";
            e.x_en_in = 1'b1;
            if (noise) e.i_aen = 1'($urandom_range(0, 1));
            q.push_back(e);
            if (!finish) begin
                e = with_fields(base(1'b1), fn, sel);
                e.tag = "wait";
                q.push_back(e);
                return;
            end
            for (int i = 1; i <= lat; i++) begin
                e = with_fields(base(1'b1), fn, sel);
                e.tag = "wait";
                if (i == lat) begin
                    e.i_aen = 1'b1;
                    e.i_aout = res;
                end
                q.push_back(e);
            end
            e = with_fields(base(1'b1), fn, sel);
            e.tag = "wb";
            e.x_we = 1'b1;
            e.i_aout = res;
            if (noise) e.i_aen = 1'($urandom_range(0, 1));
            q.push_back(e);
            if (op == 4'h3) m_z = (res == 16'h0000);
            m_pc = m_pc + 8'd1;
        end else if (op == 4'h8) begin
            m_pc = w[7:0];
        end else if (op == 4'h9) begin
            m_pc = m_z ? w[7:0] : m_pc + 8'd1;
        end else if (op == 4'hF) begin
            for (int i = 0; i < 20; i++) begin
                e = base(1'b0);
                e.tag = "halt";
                e.x_halted = 1'b1;
                e.i_start = (i % 3 != 2);
                q.push_back(e);
            end
        end else begin
            m_pc = m_pc + 8'd1;
        end
    endtask

    task automatic run_queue();
        cyc_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            @(posedge clk);
            #1;
            cyc_no++;
            check_vec($sformatf("cyc%0d_%s", cyc_no, e.tag), {25'h0, dut_vec}, {25'h0, pack_x(e)});
            start      = e.i_start;
            imem_valid = e.i_valid;
            imem_data  = e.i_data;
            alu_en_out = e.i_aen;
            alu_out    = e.i_aout;
        end
        @(negedge clk);
        #1;
    endtask

    initial begin
        bit a, s;
        logic [2:0] f;
        rst = 1'b1;
        start = 1'b0;
        imem_valid = 1'b0;
        imem_data = '0;
        alu_en_out = 1'b0;
        alu_out = '0;
        m_pc = 8'h00;
        m_ir = 16'h0000;
        m_z = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_vec("reset_outputs", {25'h0, dut_vec}, 64'h0);
        check_vec("reset_state", {61'h0, state_dbg}, {61'h0, S_IDLE});
        rst = 1'b0;

        op_table(4'h1, a, s, f);
        check_vec("ldi_table_literal", {59'h0, a, s, f}, {59'h0, 1'b1, 1'b1, 3'b000});
        op_table(4'h3, a, s, f);
        check_vec("sub_table_literal", {59'h0, a, s, f}, {59'h0, 1'b1, 1'b0, 3'b010});

        // LDI r0, 0x03 with zero-wait memory: five cycles, one EXEC pulse.
        t_idle(1'b0);
        t_idle(1'b0);
        t_idle(1'b1);
        t_instr(16'h1203, 0, 1, 16'h0003, 1'b0, 1'b1);
        check_vec("ldi_imm_literal", {48'h0, 8'h00, m_ir[7:0]}, 64'h0003);
        check_vec("ldi_pc_literal", {56'h0, m_pc}, 64'h01);
        run_queue();
        check_vec("ldi_en_pulses", en_cnt, 1);
        check_vec("ldi_we_pulses", we_cnt, 1);

        // SUB result zero -> JZ taken; SUB result nonzero -> JZ falls through.
        t_instr(16'h36C0, 0, 2, 16'h0000, 1'b1, 1'b1);
        t_instr(16'h9040, 3, 0, 16'h0000, 1'b1, 1'b1);
        check_vec("jz_taken_pc_literal", {56'h0, m_pc}, 64'h40);
        t_instr(16'h36C0, 1, 1, 16'h0005, 1'b1, 1'b1);
        t_instr(16'h9040, 0, 0, 16'h0000, 1'b0, 1'b1);
        check_vec("jz_not_taken_pc_literal", {56'h0, m_pc}, 64'h42);
        run_queue();

        // Remaining ALU ops; AND with zero result must not touch the flag.
        t_instr(16'h2E40, 0, 1, 16'h0010, 1'b1, 1'b1);
        t_instr(16'h4500, 2, 3, 16'h0000, 1'b1, 1'b1);
        t_instr(16'h5A80, 0, 1, 16'h0001, 1'b0, 1'b1);
        t_instr(16'h61C0, 1, 2, 16'h0100, 1'b1, 1'b1);
        t_instr(16'h7F00, 0, 1, 16'h0002, 1'b1, 1'b1);
        t_instr(16'h9010, 0, 0, 16'h0000, 1'b1, 1'b1);
        t_instr(16'hA123, 0, 0, 16'h0000, 1'b1, 1'b1);
        t_instr(16'h0000, 1, 0, 16'h0000, 1'b1, 1'b1);
        check_vec("unknown_nop_pc_literal", {56'h0, m_pc}, 64'h4A);
        t_instr(16'h80FF, 0, 0, 16'h0000, 1'b1, 1'b1);
        t_instr(16'h0000, 0, 0, 16'h0000, 1'b1, 1'b1);
        check_vec("pc_wrap_literal", {56'h0, m_pc}, 64'h00);
        t_instr(16'h1DAB, 0, 1, 16'h00AB, 1'b1, 1'b1);
        run_queue();
        check_vec("we_pulses_total", we_cnt, 9);

        // Reset while waiting on the ALU aborts the instruction.
        t_instr(16'h2E40, 0, 1, 16'h0000, 1'b0, 1'b0);
        run_queue();
        @(posedge clk);
        #1;
        check_vec("wait_state_before_rst", {61'h0, state_dbg}, {61'h0, S_WAIT});
        rst = 1'b1;
        #1;
        check_vec("rst_async_outputs", {25'h0, dut_vec}, 64'h0);
        check_vec("rst_async_state", {61'h0, state_dbg}, {61'h0, S_IDLE});
        alu_en_out = 1'b1;
        alu_out = 16'h0000;
        start = 1'b0;
        imem_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_vec($sformatf("post_rst_idle%0d", i), {25'h0, dut_vec}, 64'h0);
        end
        alu_en_out = 1'b0;
        check_vec("aborted_no_we", we_cnt, 9);
        check_vec("en_pulses_total", en_cnt, 10);
        m_pc = 8'h00;
        m_ir = 16'h0000;
        m_z = 1'b0;

        // Zero flag cleared by reset, then HALT ignores start pulses.
        t_idle(1'b1);
        t_instr(16'h9040, 0, 0, 16'h0000, 1'b0, 1'b1);
        check_vec("jz_after_rst_pc_literal", {56'h0, m_pc}, 64'h01);
        t_instr(16'hF000, 1, 0, 16'h0000, 1'b1, 1'b1);
        run_queue();
        check_vec("halt_flags", {61'h0, halted, busy, imem_req}, 64'h4);
        check_vec("halt_state", {61'h0, state_dbg}, {61'h0, S_HALT});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_ctrl_unit.md
Name: cpu_ctrl_unit

Overview:
- Multi-cycle control unit for the 16-bit datapath; sits directly upstream of the ALU.
- Fetches each instruction from instruction memory, decodes it, and drives the register-file read addresses and the B-operand select.
- Issues alu_func and a one-cycle alu_en_in pulse to the ALU, waits for the ALU's en_out, then pulses the register-file write enable.
- Owns the PC, the zero flag used by JZ, and the halt state.

Parameters:
PC_W, 8, program counter / instruction address width
DATA_W, 16, instruction and ALU data width

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  leaves IDLE and begins fetching at PC=0; ignored in every other state
imem_addr  output  PC_W  instruction address (= pc)
imem_req  output  1  high for the whole FETCH state
imem_data  input  DATA_W  instruction word; sampled when imem_valid=1 in FETCH
imem_valid  input  1  instruction ready; ignored outside FETCH
alu_func  output  3  ALU operation code, held from EXEC through WB
alu_en_in  output  1  one-cycle pulse in EXEC
alu_en_out  input  1  ALU result-valid
alu_out  input  DATA_W  ALU result; used only for zero detection
rf_ra  output  2  operand A register address
rf_rb  output  2  operand B register address
rf_wa  output  2  destination register address
rf_we  output  1  one-cycle write pulse in WB
sel_imm  output  1  1 selects imm_ext as ALU operand B
imm_ext  output  DATA_W  {8'h00, ir[7:0]}
busy  output  1  high in any state other than IDLE and HALT
halted  output  1  high in HALT

Behaviour:
- Reset state (rst=1, asynchronous):
  - State IDLE; pc=0; ir=0; z_reg=0.
  - All outputs 0.
- Instruction format:
  - ir[15:12] opcode; ir[11:10] rd; ir[9:8] ra; ir[7:6] rb; ir[7:0] imm8.
- Opcodes and the ALU func each one issues:
  - 0x0 NOP.
  - 0x1 LDI, func 000, sel_imm=1.
  - 0x2 ADD, func 001.
  - 0x3 SUB, func 010.
  - 0x4 AND, func 011.
  - 0x5 OR, func 100.
  - 0x6 SHL, func 101.
  - 0x7 SHR, func 110.
  - 0x8 JMP imm8.
  - 0x9 JZ imm8.
  - 0xF HALT.
  - Any other opcode is executed as a NOP.
- State transitions:
  - IDLE -> FETCH when start=1.
  - FETCH: imem_req=1. On imem_valid=1, latch ir<=imem_data and go to DECODE; otherwise wait with no timeout.
  - DECODE (1 cycle), by opcode:
    - ALU ops: drive rf_ra, rf_rb, rf_wa, sel_imm and alu_func, then go to EXEC.
    - JMP: pc<=imm8, then FETCH.
    - JZ: if z_reg=1, pc<=imm8, else pc<=pc+1; then FETCH.
    - NOP/unknown: pc<=pc+1, then FETCH.
    - HALT: go to HALT; pc unchanged.
  - EXEC (1 cycle): alu_en_in=1, then WAIT.
  - WAIT: hold until alu_en_out=1, then go to WB.
  - WB (1 cycle):
    - rf_we=1 with rf_wa=rd.
    - If opcode=SUB, z_reg<=(alu_out==0); z_reg is unchanged by every other opcode.
    - pc<=pc+1, then FETCH.
  - HALT: stays until reset; start is ignored.
- Register-file/ALU outputs (alu_func, rf_* addresses, sel_imm) hold stable from DECODE through WB.
- Latency: an ALU instruction with imem_valid in the first FETCH cycle takes 5 cycles (FETCH, DECODE, EXEC, WAIT, WB); JMP, JZ and NOP take 2.
- PC wraps 2^PC_W-1 -> 0 without error.
- alu_en_out seen outside WAIT is ignored.
- Reset asserted mid-instruction aborts it: no rf_we, pc=0, IDLE.

Decomposition:
- Shared package cpu_defs_pkg:
  - opcode constants;
  - ALU func codes 000..110 (the single source for both this block and the ALU);
  - state encoding for IDLE, FETCH, DECODE, EXEC, WAIT, WB, HALT.
- One combinational sub-module, cpu_ctrl_decode, maps opcode to alu_func, sel_imm, is_alu, is_jmp, is_jz and is_halt.

Test Plan:
- Reset then start=1, memory returns 0x1203 (LDI r0, 0x03) with zero wait -> FETCH/DECODE/EXEC/WAIT/WB over 5 cycles; one alu_en_in pulse; alu_func=000, sel_imm=1, imm_ext=0x0003; rf_we pulse with rf_wa=0; pc=1.
- SUB r1,r2,r3 (0x3E C0 form: ir=0x36C0) with alu_out=0x0000 at en_out -> z_reg=1. Following JZ 0x40 (0x9040) -> pc=0x40; with alu_out=0x0005 instead -> pc advances to next address.
- imem_valid delayed 3 cycles -> imem_req held 4 cycles, imem_addr stable, no alu_en_in until after DECODE.
- pc at 0xFF executing NOP -> pc wraps to 0x00; opcode 0xA -> treated as NOP, no rf_we.
- HALT (0xF000) -> halted=1, busy=0, imem_req=0 thereafter; start pulses ignored for 20 cycles.
- rst asserted during WAIT -> outputs 0 immediately, state IDLE, no rf_we on the later alu_en_out.
